// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes. It computes FWD/ADD/AND/OR/SUB in one cycle,
// MUL by shift-add over W cycles and shifts one bit per cycle, then registers the result with its flags.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   operation,
    input  logic [W-1:0] data1,
    input  logic [W-1:0] data2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         ZERO,
    output logic         CARRY,
    output logic         OVERFLOW,
    output logic [1:0]   fsm_state
);

    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  mcand;
    logic [W-1:0]    mplier;

    logic            accept;
    logic [W:0]      add_full;
    logic [W:0]      sub_full;
    logic [CW-1:0]   shamt;
    logic            quick;
    logic [W-1:0]    quick_res;
    logic            quick_c;
    logic            quick_v;
    logic [2*W-1:0]  acc_next;
    logic [W-1:0]    sh_next;

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready depends combinationally on out_ready so DONE can retire and accept on one edge.
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign fsm_state = state;

    assign add_full = {1'b0, data1} + {1'b0, data2};
    assign sub_full = {1'b0, data1} + {1'b0, ~data2} + {{W{1'b0}}, 1'b1};

    // Shift distance saturates at W, which already yields the all-zero / all-sign result.
    always_comb begin
        shamt = CW'(W);
        if (data2 < W'(W)) begin
            shamt = CW'(data2);
        end
    end

    always_comb begin
        quick_res = data2;
        quick_c   = 1'b0;
        quick_v   = 1'b0;
        quick     = 1'b1;
        case (operation)
            OP_FWD: quick_res = data2;
            OP_ADD: begin
                quick_res = add_full[W-1:0];
                quick_c   = add_full[W];
                quick_v   = (data1[W-1] == data2[W-1]) && (add_full[W-1] != data1[W-1]);
            end
            OP_AND: quick_res = data1 & data2;
            OP_OR:  quick_res = data1 | data2;
            OP_SUB: begin
                quick_res = sub_full[W-1:0];
                quick_c   = sub_full[W];
                quick_v   = (data1[W-1] != data2[W-1]) && (sub_full[W-1] != data1[W-1]);
            end
            OP_MUL: quick = 1'b0;
            OP_SLL, OP_SRA: begin
                quick_res = data1;
                quick     = (shamt == '0);
            end
            default: quick_res = data2;
        endcase
    end

    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign sh_next  = (op_q == OP_SLL) ? {acc[W-2:0], 1'b0} : {acc[W-1], acc[W-1:1]};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            op_q     <= OP_FWD;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            result   <= '0;
            ZERO     <= 1'b0;
            CARRY    <= 1'b0;
            OVERFLOW <= 1'b0;
        end else if (accept) begin
            op_q <= operation;
            if (quick) begin
                result   <= quick_res;
                ZERO     <= (quick_res == '0);
                CARRY    <= quick_c;
                OVERFLOW <= quick_v;
                state    <= DONE;
            end else if (operation == OP_MUL) begin
                acc    <= '0;
                mcand  <= {{W{1'b0}}, data1};
                mplier <= data2;
                cnt    <= CW'(W - 1);
                state  <= BUSY;
            end else begin
                acc   <= {{W{1'b0}}, data1};
                cnt   <= shamt - {{(CW-1){1'b0}}, 1'b1};
                state <= BUSY;
            end
        end else begin
            case (state)
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                    if (op_q == OP_MUL) begin
                        acc    <= acc_next;
                        mcand  <= {mcand[2*W-2:0], 1'b0};
                        mplier <= {1'b0, mplier[W-1:1]};
                        if (cnt == '0) begin
                            result   <= acc_next[W-1:0];
                            ZERO     <= (acc_next[W-1:0] == '0);
                            CARRY    <= 1'b0;
                            OVERFLOW <= (acc_next[2*W-1:W] != '0);
                            state    <= DONE;
                        end
                    end else begin
                        acc[W-1:0] <= sh_next;
                        if (cnt == '0) begin
                            result   <= sh_next;
                            ZERO     <= (sh_next == '0);
                            CARRY    <= 1'b0;
                            OVERFLOW <= 1'b0;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (W = 8): hand-computed results, flags and latencies,
// back-pressure hold, same-edge retire/accept and reset during a multiply.
module tb_alu_seq;

    localparam int W = 8;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    logic         CLK;
    logic         RESET_N;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   operation;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ZERO;
    logic         CARRY;
    logic         OVERFLOW;
    logic [1:0]   fsm_state;

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_errors;

    alu_seq #(.W(W)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ZERO      (ZERO),
        .CARRY     (CARRY),
        .OVERFLOW  (OVERFLOW),
        .fsm_state (fsm_state)
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for out_valid, check latency/result/flags; optionally retire it.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                          input logic ec, input logic ev, input int elat, input bit retire);
        int lat;
        logic [W-1:0] exp_res;
        @(negedge CLK);
        operation = op;
        data1     = a;
        data2     = b;
        in_valid  = 1'b1;
        #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        exp_q.push_back(er);
        @(posedge CLK);
        #1;
        in_valid  = 1'b0;
        operation = 3'($urandom_range(0, 7));
        data1     = W'($urandom_range(0, 255));
        data2     = W'($urandom_range(0, 255));
        lat = 1;
        while (!out_valid && lat < 40) begin
            check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge CLK);
            #1;
            lat++;
        end
        exp_res = exp_q.pop_front();
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_zero"}, 32'(ZERO), 32'(ez));
        check({tag, "_carry"}, 32'(CARRY), 32'(ec));
        check({tag, "_overflow"}, 32'(OVERFLOW), 32'(ev));
        if (retire) begin
            @(negedge CLK);
            out_ready = 1'b1;
            @(posedge CLK);
            #1;
            out_ready = 1'b0;
            check({tag, "_retired"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        RESET_N   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operation = OP_FWD;
        data1     = '0;
        data2     = '0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({ZERO, CARRY, OVERFLOW}), 32'd0);
        RESET_N = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        // tag, op, a, b, result, Z, C, V, latency, retire
        run_op("add_ovf",  OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        run_op("sub_zero", OP_SUB, 8'd5,  8'd5,  8'h00, 1'b1, 1'b1, 1'b0, 1, 1'b1);
        run_op("sub_brw",  OP_SUB, 8'd3,  8'd5,  8'hFE, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        run_op("sub_ovf",  OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        run_op("add_wrap", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1, 1'b1);
        run_op("fwd",      OP_FWD, 8'h12, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        run_op("and",      OP_AND, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        run_op("or",       OP_OR,  8'h30, 8'h05, 8'h35, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        run_op("mul_13x11", OP_MUL, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 1'b0, 9, 1'b1);
        run_op("mul_16x16", OP_MUL, 8'd16, 8'd16, 8'h00, 1'b1, 1'b0, 1'b1, 9, 1'b1);
        run_op("mul_ffxff", OP_MUL, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 9, 1'b1);
        run_op("sra_3",    OP_SRA, 8'h80, 8'd3,  8'hF0, 1'b0, 1'b0, 1'b0, 4, 1'b1);
        run_op("sra_9",    OP_SRA, 8'h80, 8'd9,  8'hFF, 1'b0, 1'b0, 1'b0, 9, 1'b1);
        run_op("sll_0",    OP_SLL, 8'h01, 8'd0,  8'h01, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        run_op("sll_3",    OP_SLL, 8'h01, 8'd3,  8'h08, 1'b0, 1'b0, 1'b0, 4, 1'b1);
        run_op("sll_200",  OP_SLL, 8'hFF, 8'd200, 8'h00, 1'b1, 1'b0, 1'b0, 9, 1'b1);

        // Back-pressure hold, then retire and accept on the same edge
        run_op("hold_add", OP_ADD, 8'd2, 8'd3, 8'd5, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        repeat (5) begin
            @(negedge CLK);
            check("hold_result", 32'(result), 32'd5);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge CLK);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        operation = OP_OR;
        data1     = 8'hF0;
        data2     = 8'h0F;
        #1 check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        check("b2b_result", 32'(result), 32'hFF);
        check("b2b_state_done", 32'(fsm_state), 32'd2);
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        check("b2b_retired", 32'(out_valid), 32'd0);

        // Reset in the middle of a multiply
        @(negedge CLK);
        operation = OP_MUL;
        data1     = 8'd13;
        data2     = 8'd11;
        in_valid  = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("mid_mul_busy", 32'(fsm_state), 32'd1);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_flags", 32'({ZERO, CARRY, OVERFLOW}), 32'd0);
        check("mid_rst_state", 32'(fsm_state), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1 check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        run_op("post_rst_add", OP_ADD, 8'd2, 8'd3, 8'd5, 1'b0, 1'b0, 1'b0, 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
